// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS controller: FSM states, error codes,
// and the DDS FIFO address map.
package dds_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CLEAR      = 3'd1,
    LOAD_THETA = 3'd2,
    LOAD_DELTA = 3'd3,
    LOAD_AMPL  = 3'd4,
    RUN        = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_EARLY_LAST = 2'd1,
    ERR_NO_LAST    = 2'd2,
    ERR_TIMEOUT    = 2'd3
  } err_e;

  localparam int THETAS    = 0;
  localparam int DELTAS    = 1;
  localparam int AMPLS     = 2;
  // Sized by the caller; -1 truncates to all ones at any address width.
  localparam int PARK_ADDR = -1;

  function automatic int load_addr(input state_e s);
    case (s)
      LOAD_THETA: load_addr = THETAS;
      LOAD_DELTA: load_addr = DELTAS;
      LOAD_AMPL:  load_addr = AMPLS;
      default:    load_addr = PARK_ADDR;
    endcase
  endfunction

endpackage

// File: rtl/dds_slot_counter.sv
// Mod-N slot counter with synchronous clear (dominant over enable) and a
// combinational wrap flag that is high on the enabled cycle at count N-1.
module dds_slot_counter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         a_rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && (count == W'(N - 1));

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/dds_ctrl.sv
// Sequencer that clears, loads and runs the multi-channel DDS datapath.
// Optional load-stall timeout is built when DDS_CTRL_TIMEOUT_EN is defined.
module dds_ctrl
  import dds_pkg::*;
#(
  parameter int SIG_WIDTH   = 16,
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 9,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        a_rst,
  input  logic                        i_cfg_start,
  input  logic                        i_cfg_stop,
  input  logic [SIG_WIDTH-1:0]        i_s_data,
  input  logic                        i_s_valid,
  input  logic                        i_s_last,
  output logic                        o_s_ready,
  output logic                        o_dds_rst,
  output logic                        o_dds_start,
  output logic [ADDR_W-1:0]           o_dds_addrs,
  output logic [SIG_WIDTH-1:0]        o_dds_fifo_data,
  output logic                        o_busy,
  output logic                        o_running,
  output logic [$clog2(NUM_CH)-1:0]   o_ch_idx,
  output logic                        o_frame,
  output logic [1:0]                  o_err
);

  localparam int CW = $clog2(NUM_CH);

  state_e        state;
  err_e          err;
  logic          load, beat, beat_wrap, final_slot, ch_wrap, timeout;
  logic [CW-1:0] beat_cnt;

  // Handshake: a word transfers on every cycle where i_s_valid and o_s_ready
  // are both high; o_s_ready is registered and never depends on i_s_valid.
  // A beat that coincides with a stop or an error is still written to the DDS.
  assign load       = (state == LOAD_THETA) || (state == LOAD_DELTA) || (state == LOAD_AMPL);
  assign beat       = i_s_valid && o_s_ready;
  assign final_slot = (state == LOAD_AMPL) && (beat_cnt == CW'(NUM_CH - 1));
  assign o_busy     = (state == CLEAR) || load;
  assign o_running  = (state == RUN);
  assign o_err      = err;

  // The DDS shifts whatever FIFO is addressed, so park the port off every beat.
  always_comb begin
    o_dds_addrs     = ADDR_W'(PARK_ADDR);
    o_dds_fifo_data = '0;
    if (beat) begin
      o_dds_addrs     = ADDR_W'(load_addr(state));
      o_dds_fifo_data = i_s_data;
    end
  end

  dds_slot_counter #(.N(NUM_CH), .W(CW)) u_beat_cnt (
    .clk   (clk),
    .a_rst (a_rst),
    .clr   (state == CLEAR),
    .en    (beat),
    .count (beat_cnt),
    .wrap  (beat_wrap)
  );

  dds_slot_counter #(.N(NUM_CH), .W(CW)) u_ch_cnt (
    .clk   (clk),
    .a_rst (a_rst),
    .clr   (o_running && (i_cfg_start || i_cfg_stop)),
    .en    (o_running),
    .count (o_ch_idx),
    .wrap  (ch_wrap)
  );

`ifdef DDS_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      to_cnt <= '0;
    end else if (!load || beat) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = load && !beat && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state       <= IDLE;
      err         <= ERR_NONE;
      o_s_ready   <= 1'b0;
      o_dds_rst   <= 1'b0;
      o_dds_start <= 1'b0;
      o_frame     <= 1'b0;
    end else begin
      o_dds_rst <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cfg_start && !i_cfg_stop) begin
            state     <= CLEAR;
            o_dds_rst <= 1'b1;
            err       <= ERR_NONE;
          end
        end
        CLEAR: begin
          state     <= LOAD_THETA;
          o_s_ready <= 1'b1;
        end
        LOAD_THETA, LOAD_DELTA, LOAD_AMPL: begin
          if (i_cfg_stop) begin
            state     <= IDLE;
            o_s_ready <= 1'b0;
          end else if (timeout) begin
            state     <= IDLE;
            o_s_ready <= 1'b0;
            err       <= ERR_TIMEOUT;
          end else if (beat) begin
            if (i_s_last && !final_slot) begin
              state     <= IDLE;
              o_s_ready <= 1'b0;
              err       <= ERR_EARLY_LAST;
            end else if (final_slot && !i_s_last) begin
              state     <= IDLE;
              o_s_ready <= 1'b0;
              err       <= ERR_NO_LAST;
            end else if (beat_wrap) begin
              case (state)
                LOAD_THETA: state <= LOAD_DELTA;
                LOAD_DELTA: state <= LOAD_AMPL;
                default: begin
                  state       <= RUN;
                  o_s_ready   <= 1'b0;
                  o_dds_start <= 1'b1;
                  o_frame     <= 1'b1;
                end
              endcase
            end
          end
        end
        RUN: begin
          if (i_cfg_stop) begin
            state       <= IDLE;
            o_dds_start <= 1'b0;
            o_frame     <= 1'b0;
          end else if (i_cfg_start) begin
            state       <= CLEAR;
            o_dds_rst   <= 1'b1;
            o_dds_start <= 1'b0;
            o_frame     <= 1'b0;
            err         <= ERR_NONE;
          end else begin
            o_frame <= ch_wrap;
          end
        end
        default: begin
          state       <= IDLE;
          o_s_ready   <= 1'b0;
          o_dds_start <= 1'b0;
          o_frame     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_ctrl.sv
// Self-checking bench for dds_ctrl: scoreboard of expected DDS FIFO writes plus
// per-scenario checks of sequencing, framing, error codes and reset.
module tb_dds_ctrl;

  localparam int SW = 16;
  localparam int NC = 4;
  localparam int AW = 9;
  localparam int TO = 16;
  localparam logic [AW-1:0] PARK = '1;

  logic          clk, a_rst;
  logic          i_cfg_start, i_cfg_stop;
  logic [SW-1:0] i_s_data;
  logic          i_s_valid, i_s_last;
  logic          o_s_ready, o_dds_rst, o_dds_start;
  logic [AW-1:0] o_dds_addrs;
  logic [SW-1:0] o_dds_fifo_data;
  logic          o_busy, o_running, o_frame;
  logic [1:0]    o_ch_idx;
  logic [1:0]    o_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [AW+SW-1:0] exp_q[$];
  logic [AW+SW-1:0] mon_exp;

  dds_ctrl #(.SIG_WIDTH(SW), .NUM_CH(NC), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk             (clk),
    .a_rst           (a_rst),
    .i_cfg_start     (i_cfg_start),
    .i_cfg_stop      (i_cfg_stop),
    .i_s_data        (i_s_data),
    .i_s_valid       (i_s_valid),
    .i_s_last        (i_s_last),
    .o_s_ready       (o_s_ready),
    .o_dds_rst       (o_dds_rst),
    .o_dds_start     (o_dds_start),
    .o_dds_addrs     (o_dds_addrs),
    .o_dds_fifo_data (o_dds_fifo_data),
    .o_busy          (o_busy),
    .o_running       (o_running),
    .o_ch_idx        (o_ch_idx),
    .o_frame         (o_frame),
    .o_err           (o_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!a_rst && ((o_dds_addrs !== PARK) || (i_s_valid && o_s_ready))) begin
      n_cmp++;
      if (!(i_s_valid && o_s_ready)) begin
        n_bad++;
        $display("FAIL write_spurious: addr=%0h data=%0h with no beat, required addr=%0h", o_dds_addrs, o_dds_fifo_data, PARK);
      end else if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL write_unexpected: addr=%0h data=%0h, required no write", o_dds_addrs, o_dds_fifo_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({o_dds_addrs, o_dds_fifo_data} !== mon_exp)
        begin
          n_bad++;
          $display("FAIL write_data: got addr=%0h data=%0h, required addr=%0h data=%0h",
                   o_dds_addrs, o_dds_fifo_data, mon_exp[AW+SW-1:SW], mon_exp[SW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic pulse(input logic st, input logic sp);
    i_cfg_start = st;
    i_cfg_stop  = sp;
    @(posedge clk); #1;
    i_cfg_start = 1'b0;
    i_cfg_stop  = 1'b0;
  endtask

  task automatic send_word(input logic [SW-1:0] d, input logic lst, input int gap, input logic [AW-1:0] a);
    int w;
    repeat (gap) begin @(posedge clk); #1; end
    exp_q.push_back({a, d});
    i_s_valid = 1'b1;
    i_s_data  = d;
    i_s_last  = lst;
    w = 0;
    @(negedge clk);
    while (!o_s_ready && w < 20) begin @(negedge clk); w++; end
    n_cmp++;
    if (!o_s_ready) begin
      n_bad++;
      $display("FAIL ready_wait: ready=%0b after 20 cycles, required 1", o_s_ready);
      void'(exp_q.pop_back());
    end
    @(posedge clk); #1;
    i_s_valid = 1'b0;
    i_s_last  = 1'b0;
  endtask

  // gap < 0 picks a random 0..3 idle cycles before each word.
  task automatic load_words(input logic [SW-1:0] base, input int gap, input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      send_word(base + SW'(i), (i == last_at), (gap < 0) ? int'($urandom_range(0, 3)) : gap, AW'(i / NC));
    end
  endtask

  task automatic start_to_load();
    pulse(1'b1, 1'b0);
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    a_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({o_s_ready, o_dds_rst, o_dds_start, o_busy, o_running, o_frame, o_ch_idx, o_err, o_dds_addrs, o_dds_fifo_data}
        !== {6'b0, 2'd0, 2'd0, PARK, 16'h0}) begin
      n_bad++;
      $display("FAIL reset_held: ready=%0b rst=%0b start=%0b busy=%0b run=%0b addr=%0h err=%0d, required zeros and addr=%0h",
               o_s_ready, o_dds_rst, o_dds_start, o_busy, o_running, o_dds_addrs, o_err, PARK);
    end
    a_rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({o_s_ready, o_dds_rst, o_dds_start, o_busy, o_running, o_frame, o_err, o_dds_addrs} !== {6'b0, 2'd0, PARK}) begin
      n_bad++;
      $display("FAIL reset_idle: ready=%0b busy=%0b run=%0b addr=%0h, required idle", o_s_ready, o_busy, o_running, o_dds_addrs);
    end
  endtask

  task automatic test_nominal();
    pulse(1'b1, 1'b0);
    n_cmp++;
    if ({o_dds_rst, o_busy, o_s_ready, o_running} !== 4'b1100) begin
      n_bad++;
      $display("FAIL clear_cycle: rst,busy,ready,run=%b, required 1100", {o_dds_rst, o_busy, o_s_ready, o_running});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({o_dds_rst, o_s_ready, o_busy} !== 3'b011) begin
      n_bad++;
      $display("FAIL first_ready: rst,ready,busy=%b, required 011", {o_dds_rst, o_s_ready, o_busy});
    end
    load_words(16'h1000, 0, 12, 11);
    n_cmp++;
    if ({o_dds_start, o_running, o_busy, o_s_ready, o_frame, o_ch_idx, o_err} !== {5'b11001, 2'd0, 2'd0}) begin
      n_bad++;
      $display("FAIL run_entry: start=%0b run=%0b busy=%0b ready=%0b frame=%0b idx=%0d err=%0d, required 1 1 0 0 1 0 0",
               o_dds_start, o_running, o_busy, o_s_ready, o_frame, o_ch_idx, o_err);
    end
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({o_ch_idx, o_frame, o_dds_start} !== {2'(k % NC), (k % NC == 0), 1'b1}) begin
        n_bad++;
        $display("FAIL run_slot[%0d]: idx=%0d frame=%0b start=%0b, required idx=%0d frame=%0b start=1",
                 k, o_ch_idx, o_frame, o_dds_start, k % NC, (k % NC == 0));
      end
    end
  endtask

  task automatic test_gapped();
    pulse(1'b0, 1'b1);
    n_cmp++;
    if ({o_dds_start, o_running, o_busy, o_ch_idx, o_frame} !== 6'b0) begin
      n_bad++;
      $display("FAIL stop_run: start=%0b run=%0b busy=%0b idx=%0d frame=%0b, required all 0",
               o_dds_start, o_running, o_busy, o_ch_idx, o_frame);
    end
    start_to_load();
    load_words(16'h2000, 2, 12, 11);
    n_cmp++;
    if ({o_dds_start, o_running, o_err} !== {2'b11, 2'd0}) begin
      n_bad++;
      $display("FAIL gapped_run: start=%0b run=%0b err=%0d, required 1 1 0", o_dds_start, o_running, o_err);
    end
  endtask

  task automatic test_stop_start_same();
    pulse(1'b1, 1'b1);
    n_cmp++;
    if ({o_dds_start, o_running, o_busy, o_dds_rst} !== 4'b0) begin
      n_bad++;
      $display("FAIL stop_wins: start=%0b run=%0b busy=%0b rst=%0b, required all 0", o_dds_start, o_running, o_busy, o_dds_rst);
    end
    @(posedge clk); #1;
    pulse(1'b1, 1'b0);
    n_cmp++;
    if ({o_dds_rst, o_busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL restart_clear: rst=%0b busy=%0b, required 1 1", o_dds_rst, o_busy);
    end
    @(posedge clk); #1;
    load_words(16'h3000, -1, 12, 11);
    pulse(1'b1, 1'b0);
    n_cmp++;
    if ({o_dds_rst, o_busy, o_running, o_dds_start} !== 4'b1100) begin
      n_bad++;
      $display("FAIL run_restart: rst,busy,run,start=%b, required 1100", {o_dds_rst, o_busy, o_running, o_dds_start});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stop_during_load();
    load_words(16'h3800, 0, 2, -1);
    pulse(1'b1, 1'b0);
    n_cmp++;
    if ({o_s_ready, o_busy, o_dds_rst} !== 3'b110) begin
      n_bad++;
      $display("FAIL start_ignored: ready,busy,rst=%b, required 110", {o_s_ready, o_busy, o_dds_rst});
    end
    pulse(1'b0, 1'b1);
    n_cmp++;
    if ({o_busy, o_s_ready, o_err} !== {2'b00, 2'd0}) begin
      n_bad++;
      $display("FAIL stop_abort: busy=%0b ready=%0b err=%0d, required 0 0 0", o_busy, o_s_ready, o_err);
    end
  endtask

  task automatic test_last_errors();
    start_to_load();
    load_words(16'h4000, 0, 5, 4);
    n_cmp++;
    if ({o_err, o_busy, o_s_ready, o_dds_start, o_running} !== {2'd1, 4'b0}) begin
      n_bad++;
      $display("FAIL early_last: err=%0d busy=%0b ready=%0b start=%0b, required err=1 idle", o_err, o_busy, o_s_ready, o_dds_start);
    end
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (o_err !== 2'd1) begin
      n_bad++;
      $display("FAIL err_sticky: err=%0d, required 1", o_err);
    end
    pulse(1'b1, 1'b0);
    n_cmp++;
    if ({o_err, o_dds_rst} !== {2'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL err_clear: err=%0d rst=%0b, required 0 1", o_err, o_dds_rst);
    end
    @(posedge clk); #1;
    load_words(16'h5000, 0, 12, -1);
    n_cmp++;
    if ({o_err, o_busy, o_dds_start} !== {2'd2, 2'b00}) begin
      n_bad++;
      $display("FAIL missing_last: err=%0d busy=%0b start=%0b, required 2 0 0", o_err, o_busy, o_dds_start);
    end
    start_to_load();
    load_words(16'h6000, 0, NC, NC - 1);
    n_cmp++;
    if ({o_err, o_busy} !== {2'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL last_at_wrap: err=%0d busy=%0b, required 1 0", o_err, o_busy);
    end
  endtask

  task automatic test_reset_mid_load();
    start_to_load();
    load_words(16'h7000, 0, 6, -1);
    i_s_valid = 1'b1;
    i_s_data  = 16'h7FFF;
    #1 a_rst = 1'b1;
    #1;
    n_cmp++;
    if ({o_s_ready, o_busy, o_running, o_dds_start, o_dds_rst, o_frame, o_ch_idx, o_err, o_dds_addrs, o_dds_fifo_data}
        !== {6'b0, 2'd0, 2'd0, PARK, 16'h0}) begin
      n_bad++;
      $display("FAIL async_reset: ready=%0b busy=%0b addr=%0h data=%0h err=%0d, required idle addr=%0h",
               o_s_ready, o_busy, o_dds_addrs, o_dds_fifo_data, o_err, PARK);
    end
    i_s_valid = 1'b0;
    @(posedge clk); #1;
    a_rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    start_to_load();
`ifdef DDS_CTRL_TIMEOUT_EN
    repeat (TO - 1) begin @(posedge clk); #1; end
    n_cmp++;
    if ({o_busy, o_err} !== {1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL timeout_early: busy=%0b err=%0d, required 1 0", o_busy, o_err);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({o_err, o_busy, o_s_ready} !== {2'd3, 2'b00}) begin
      n_bad++;
      $display("FAIL timeout: err=%0d busy=%0b ready=%0b, required 3 0 0", o_err, o_busy, o_s_ready);
    end
`else
    repeat (3 * TO) begin @(posedge clk); #1; end
    n_cmp++;
    if ({o_busy, o_s_ready, o_err} !== {2'b11, 2'd0}) begin
      n_bad++;
      $display("FAIL no_timeout: busy=%0b ready=%0b err=%0d, required 1 1 0", o_busy, o_s_ready, o_err);
    end
    pulse(1'b0, 1'b1);
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    i_cfg_start = 1'b0;
    i_cfg_stop  = 1'b0;
    i_s_data    = '0;
    i_s_valid   = 1'b0;
    i_s_last    = 1'b0;
    test_reset();
    test_nominal();
    test_gapped();
    test_stop_start_same();
    test_stop_during_load();
    test_last_errors();
    test_reset_mid_load();
    test_timeout();
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: %0d writes outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dds_ctrl.md
Name: dds_ctrl

Overview:
Sequencer that configures and runs the multi-channel dds datapath. It accepts a stream of per-channel configuration words (thetas, deltas, amplitudes) over a valid/ready interface. It clears the DDS shift registers, writes each word into the correct FIFO via the address/data port, then asserts start so the FIFOs circulate. It also provides stop/restart control, a channel-slot counter for downstream framing, and error status.

Parameters:
SIG_WIDTH, 16, config word and DDS data width
NUM_CH, 4, channels per FIFO (must equal DDS shift_reg depth), >=2
ADDR_W, 9, DDS address port width
TIMEOUT_CYC, 1024, idle-beat limit during load (used only with DDS_CTRL_TIMEOUT_EN)

Ports:
clk  in  1  single clock
a_rst  in  1  asynchronous, active-high reset
i_cfg_start  in  1  pulse: begin (re)configuration
i_cfg_stop  in  1  pulse: stop circulation
i_s_data  in  SIG_WIDTH  config word
i_s_valid  in  1  config word valid
i_s_last  in  1  marks final word (last amplitude)
o_s_ready  out  1  controller accepts word
o_dds_rst  out  1  to DDS i_dds_rst
o_dds_start  out  1  to DDS i_dds_start
o_dds_addrs  out  ADDR_W  to DDS i_dds_addrs
o_dds_fifo_data  out  SIG_WIDTH  to DDS i_dds_fifo_data
o_busy  out  1  CLEAR or LOAD_* state
o_running  out  1  RUN state
o_ch_idx  out  $clog2(NUM_CH)  slot index while running
o_frame  out  1  one-cycle pulse when o_ch_idx wraps to 0
o_err  out  2  sticky: 0 none, 1 early last, 2 missing last, 3 timeout

Behaviour:
- Clock and reset: one clock, clk. a_rst is asynchronous and active-high.
- Reset values:
  - state=IDLE.
  - All outputs 0, except o_dds_addrs=PARK_ADDR (all ones).
  - o_s_ready=0, o_err=0.
- Addressing rule: whenever start=0, the DDS shifts the addressed FIFO every cycle. o_dds_addrs must therefore equal PARK_ADDR on every cycle that is not an accepted beat.
- States:
  - IDLE: i_cfg_start goes to CLEAR.
  - CLEAR: lasts 1 cycle. o_dds_rst=1, o_err cleared. Then goes to LOAD_THETA.
  - LOAD_THETA, LOAD_DELTA, LOAD_AMPL: o_s_ready=1.
    - On each beat (valid&ready), same cycle: o_dds_addrs = 0, 1 or 2 respectively, and o_dds_fifo_data = i_s_data (combinational from the beat).
    - A beat counter counts 0..NUM_CH-1. At NUM_CH-1 it resets to 0 and the state advances.
    - LOAD_AMPL with count NUM_CH-1 goes to RUN.
  - RUN: o_dds_start=1 (registered, asserted the first cycle in RUN), o_s_ready=0.
    - o_ch_idx increments every cycle from 0 and wraps at NUM_CH-1.
    - o_frame=1 on the cycle o_ch_idx=0.
    - i_cfg_stop goes to IDLE; o_dds_start drops next cycle. The FIFO contents are retained.
    - i_cfg_start goes to CLEAR (restart).
- Last checking:
  - i_s_last=1 on any beat other than the final amplitude: o_err=1, go to IDLE (FIFOs left partial).
  - Final amplitude beat with i_s_last=0: o_err=2, go to IDLE.
- Simultaneous events:
  - i_cfg_start and i_cfg_stop together: stop wins.
  - i_cfg_start during CLEAR or LOAD_*: ignored.
  - i_cfg_stop during LOAD_*: abort to IDLE, o_err unchanged.
- o_err holds until the next CLEAR.
- Reset mid-load: immediate IDLE. The partially loaded FIFOs are cleared on the next CLEAR.
- Latency: start pulse to first ready is 2 cycles. The final beat to o_dds_start=1 is 1 cycle.

Optional Feature:
DDS_CTRL_TIMEOUT_EN:
- Defined: a counter runs in LOAD_* and resets on every beat. When it reaches TIMEOUT_CYC-1 with no beat: o_err=3, go to IDLE.
- Undefined: no counter; load waits indefinitely. o_err never equals 3.

Decomposition:
- dds_pkg holds:
  - state enum typedef (IDLE, CLEAR, LOAD_THETA, LOAD_DELTA, LOAD_AMPL, RUN)
  - address constants THETAS=0, DELTAS=1, AMPLS=2, PARK_ADDR='1
  - err code enum
- One sub-module, dds_slot_counter: a mod-NUM_CH counter with clear, enable and wrap pulse. Instantiated once for the load beat counter and once for o_ch_idx.

Test Plan:
- Nominal load, NUM_CH=4: start, then 12 beats 0x1000..0x100B, last on beat 12 -> o_dds_rst high 1 cycle, addrs 0,0,0,0,1,…,2, o_dds_start=1 the cycle after beat 12, o_frame every 4 cycles.
- Gapped valid (every 3rd cycle) -> addrs=PARK_ADDR on all non-beat cycles, no spurious FIFO writes; DDS output matches the model.
- Early last on beat 5 -> o_err=1, IDLE, o_dds_start=0; the next start clears o_err to 0.
- RUN, then stop+start same cycle -> IDLE, o_dds_start=0 next cycle; a later start alone -> CLEAR then reload.
- a_rst asserted mid LOAD_DELTA -> outputs at reset values asynchronously, o_dds_addrs=PARK_ADDR.
- (DDS_CTRL_TIMEOUT_EN, TIMEOUT_CYC=16) valid stalls 16 cycles in LOAD_THETA -> o_err=3, IDLE.
